// File: rtl/phasediff_pkg.sv
// Shared types and helpers for the multi-channel neuron phase detector.
// Holds the per-channel state encoding, width helpers and the accumulator saturating add.
package phasediff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        LAG  = 2'd2
    } phd_state_t;

    // Working width for the saturating add; comfortably wider than any accumulator or lag.
    localparam int SAT_W = 64;

    function automatic int diff_width(input int cnt_w);
        return cnt_w + 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] delta,
        input int                      acc_w
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sum = acc + delta;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (acc_w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/phasediff_ch.sv
// One phase-detector channel: edge detect, lead/lag FSM with timeout, phase bin, accumulator.
// Optional macro PHASEDIFF_DEADBAND_EN keeps phase_count still for lags within DEADBAND.
module phasediff_ch
    import phasediff_pkg::*;
#(
    parameter int CNT_W       = 12,
    parameter int MAX_CNT     = 4095,
    parameter int PHASE_STEPS = 16,
    parameter int PC_W        = 4,
    parameter int ACC_W       = 16,
    parameter int DEADBAND    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    nin,
    input  logic                    nout,
    output logic signed [CNT_W:0]   diff_out,
    output logic                    diff_valid,
    output logic                    timeout,
    output logic [PC_W-1:0]         phase_count,
    output logic signed [ACC_W-1:0] phi_out
);

    phd_state_t              state;
    logic                    prev_nin;
    logic                    prev_nout;
    logic                    rin;
    logic                    rout;
    logic [CNT_W-1:0]        cnt;
    logic                    emit;
    logic                    big_lag;
    logic                    step_up;
    logic                    step_dn;
    logic signed [CNT_W:0]   diff_new;
    logic [PC_W-1:0]         phase_up;
    logic [PC_W-1:0]         phase_dn;

`ifdef PHASEDIFF_DEADBAND_EN
    localparam int DB_EFF = DEADBAND;
`else
    localparam int DB_EFF = DEADBAND * 0;
`endif

    assign rin  = nin & ~prev_nin;
    assign rout = nout & ~prev_nout;

    // A closing edge always wins, so the opening-edge direction alone decides the sign.
    assign emit = ((state == IDLE) && rin && rout) ||
                  ((state == LEAD) && rout) ||
                  ((state == LAG) && rin);

    always_comb begin
        diff_new = '0;
        if (state == LEAD) begin
            diff_new = $signed({1'b0, cnt});
        end else if (state == LAG) begin
            diff_new = -$signed({1'b0, cnt});
        end
    end

    assign big_lag  = cnt > CNT_W'(DB_EFF);
    assign step_up  = emit && (state == LEAD) && big_lag;
    assign step_dn  = emit && (state == LAG) && big_lag;
    assign phase_up = (phase_count == PC_W'(PHASE_STEPS - 1)) ? '0 : phase_count + PC_W'(1);
    assign phase_dn = (phase_count == '0) ? PC_W'(PHASE_STEPS - 1) : phase_count - PC_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_nin    <= 1'b0;
            prev_nout   <= 1'b0;
            diff_out    <= '0;
            diff_valid  <= 1'b0;
            timeout     <= 1'b0;
            phase_count <= '0;
            phi_out     <= '0;
        end else if (clear) begin
            state       <= IDLE;
            cnt         <= '0;
            prev_nin    <= 1'b0;
            prev_nout   <= 1'b0;
            diff_out    <= '0;
            diff_valid  <= 1'b0;
            timeout     <= 1'b0;
            phase_count <= '0;
            phi_out     <= '0;
        end else begin
            prev_nin   <= nin;
            prev_nout  <= nout;
            diff_valid <= 1'b0;
            timeout    <= 1'b0;
            if (emit) begin
                diff_out   <= diff_new;
                diff_valid <= 1'b1;
                phi_out    <= ACC_W'(sat_add(SAT_W'(phi_out), SAT_W'(diff_new), ACC_W));
            end
            if (step_up) begin
                phase_count <= phase_up;
            end else if (step_dn) begin
                phase_count <= phase_dn;
            end
            unique case (state)
                IDLE: begin
                    if (rin && !rout) begin
                        state <= LEAD;
                        cnt   <= CNT_W'(1);
                    end else if (rout && !rin) begin
                        state <= LAG;
                        cnt   <= CNT_W'(1);
                    end
                end
                LEAD: begin
                    if (rout) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (rin) begin
                        cnt <= CNT_W'(1);
                    end else if (cnt == CNT_W'(MAX_CNT)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LAG: begin
                    if (rin) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (rout) begin
                        cnt <= CNT_W'(1);
                    end else if (cnt == CNT_W'(MAX_CNT)) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/phasediff_array.sv
// N_CH independent neuron phase detectors with outputs packed channel 0 in the low bits.
// Optional macro PHASEDIFF_DEADBAND_EN is forwarded to every channel.
module phasediff_array
    import phasediff_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 12,
    parameter int MAX_CNT     = 4095,
    parameter int PHASE_STEPS = 16,
    parameter int PC_W        = 4,
    parameter int ACC_W       = 16,
    parameter int DEADBAND    = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic [N_CH-1:0]                   nin,
    input  logic [N_CH-1:0]                   nout,
    output logic [N_CH*diff_width(CNT_W)-1:0] diff_out,
    output logic [N_CH-1:0]                   diff_valid,
    output logic [N_CH-1:0]                   timeout,
    output logic [N_CH*PC_W-1:0]              phase_count,
    output logic [N_CH*ACC_W-1:0]             phi_out
);

    localparam int DW = diff_width(CNT_W);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        phasediff_ch #(
            .CNT_W       (CNT_W),
            .MAX_CNT     (MAX_CNT),
            .PHASE_STEPS (PHASE_STEPS),
            .PC_W        (PC_W),
            .ACC_W       (ACC_W),
            .DEADBAND    (DEADBAND)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear),
            .nin         (nin[g]),
            .nout        (nout[g]),
            .diff_out    (diff_out[g*DW +: DW]),
            .diff_valid  (diff_valid[g]),
            .timeout     (timeout[g]),
            .phase_count (phase_count[g*PC_W +: PC_W]),
            .phi_out     (phi_out[g*ACC_W +: ACC_W])
        );
    end

endmodule

// File: tb/tb_phasediff_array.sv
// Directed bench for phasediff_array: lag sign/size, phase wrap, saturation, timeout, clear, reset.
// Expectations follow PHASEDIFF_DEADBAND_EN when the bench is built with that macro.
module tb_phasediff_array;

    localparam int N_CH        = 4;
    localparam int CNT_W       = 12;
    localparam int MAX_CNT     = 200;
    localparam int PHASE_STEPS = 16;
    localparam int PC_W        = 4;
    localparam int ACC_W       = 8;
    localparam int DEADBAND    = 2;
    localparam int DW          = CNT_W + 1;

`ifdef PHASEDIFF_DEADBAND_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic                     clk;
    logic                     reset;
    logic                     clear;
    logic [N_CH-1:0]          nin;
    logic [N_CH-1:0]          nout;
    logic [N_CH*DW-1:0]       diff_out;
    logic [N_CH-1:0]          diff_valid;
    logic [N_CH-1:0]          timeout;
    logic [N_CH*PC_W-1:0]     phase_count;
    logic [N_CH*ACC_W-1:0]    phi_out;

    int checks = 0;
    int errors = 0;

    phasediff_array #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .MAX_CNT     (MAX_CNT),
        .PHASE_STEPS (PHASE_STEPS),
        .PC_W        (PC_W),
        .ACC_W       (ACC_W),
        .DEADBAND    (DEADBAND)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .nin         (nin),
        .nout        (nout),
        .diff_out    (diff_out),
        .diff_valid  (diff_valid),
        .timeout     (timeout),
        .phase_count (phase_count),
        .phi_out     (phi_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint get_diff(input int ch);
        return longint'($signed(diff_out[ch*DW +: DW]));
    endfunction

    function automatic longint get_phase(input int ch);
        return longint'(phase_count[ch*PC_W +: PC_W]);
    endfunction

    function automatic longint get_phi(input int ch);
        return longint'($signed(phi_out[ch*ACC_W +: ACC_W]));
    endfunction

    task automatic check_output(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_chan(input string tag, input int ch, input longint v,
                              input longint d, input longint p, input longint phi);
        check_output($sformatf("%s_valid", tag), longint'(diff_valid[ch]), v);
        check_output($sformatf("%s_diff", tag), get_diff(ch), d);
        check_output($sformatf("%s_phase", tag), get_phase(ch), p);
        check_output($sformatf("%s_phi", tag), get_phi(ch), phi);
    endtask

    // Opening edge, then the closing edge lag cycles later; returns one cycle after the close.
    task automatic apply_stimulus(input int ch, input bit nin_first, input int lag);
        @(negedge clk);
        if (lag == 0) begin
            nin[ch]  = 1'b1;
            nout[ch] = 1'b1;
        end else if (nin_first) begin
            nin[ch] = 1'b1;
        end else begin
            nout[ch] = 1'b1;
        end
        for (int i = 1; i <= lag; i++) begin
            @(negedge clk);
            nin[ch]  = 1'b0;
            nout[ch] = 1'b0;
        end
        if (lag > 0) begin
            if (nin_first) nout[ch] = 1'b1;
            else           nin[ch]  = 1'b1;
        end
        @(negedge clk);
        nin[ch]  = 1'b0;
        nout[ch] = 1'b0;
    endtask

    initial begin
        int  t_cycle;
        bit  seen_valid;

        reset = 1'b0;
        clear = 1'b0;
        nin   = '0;
        nout  = '0;
        repeat (2) @(negedge clk);
        check_output("rst_diff_bus", longint'(diff_out), 0);
        check_output("rst_phase_bus", longint'(phase_count), 0);
        check_output("rst_phi_bus", longint'(phi_out), 0);
        check_output("rst_valid_tout", longint'({diff_valid, timeout}), 0);
        reset = 1'b1;
        @(negedge clk);

        apply_stimulus(0, 1'b1, 3);
        check_chan("lead3", 0, 1, 3, 1, 3);
        check_output("lead3_other_valid", longint'(diff_valid[3:1]), 0);
        @(negedge clk);
        check_output("lead3_pulse_end", longint'(diff_valid[0]), 0);
        check_output("lead3_diff_hold", get_diff(0), 3);

        apply_stimulus(1, 1'b0, 5);
        check_chan("lag5", 1, 1, -5, 15, -5);

        apply_stimulus(2, 1'b1, 0);
        check_chan("simul", 2, 1, 0, 0, 0);

        apply_stimulus(0, 1'b1, 100);
        check_chan("sat_pos1", 0, 1, 100, 2, 103);
        apply_stimulus(0, 1'b1, 100);
        check_chan("sat_pos2", 0, 1, 100, 3, 127);

        apply_stimulus(1, 1'b0, 100);
        check_chan("sat_neg1", 1, 1, -100, 14, -105);
        apply_stimulus(1, 1'b0, 100);
        check_chan("sat_neg2", 1, 1, -100, 13, -128);

        // Lone nin on channel 3 must time out MAX_CNT+1 cycles after the edge is sampled.
        t_cycle    = 0;
        seen_valid = 1'b0;
        @(negedge clk);
        nin[3] = 1'b1;
        for (int i = 1; i <= MAX_CNT + 100 && t_cycle == 0; i++) begin
            @(negedge clk);
            nin[3] = 1'b0;
            if (diff_valid[3]) seen_valid = 1'b1;
            if (timeout[3]) t_cycle = i;
        end
        check_output("tout_cycle", t_cycle, MAX_CNT + 1);
        check_output("tout_no_valid", longint'(seen_valid), 0);
        @(negedge clk);
        check_output("tout_pulse_end", longint'(timeout[3]), 0);
        apply_stimulus(3, 1'b0, 2);
        check_chan("after_tout", 3, 1, -2, DB ? 0 : 15, -2);

        @(negedge clk);
        nin[2] = 1'b1;
        @(negedge clk);
        nin[2] = 1'b0;
        @(negedge clk);
        apply_stimulus(2, 1'b1, 2);
        check_chan("restart", 2, 1, 2, DB ? 0 : 1, 2);
        apply_stimulus(2, 1'b1, 3);
        check_chan("lead3_db", 2, 1, 3, DB ? 1 : 2, 5);

        // Closing nout together with a fresh nin: the nin must not open a new measurement.
        @(negedge clk);
        nin[0] = 1'b1;
        @(negedge clk);
        nin[0] = 1'b0;
        @(negedge clk);
        nin[0]  = 1'b1;
        nout[0] = 1'b1;
        @(negedge clk);
        nin[0]  = 1'b0;
        nout[0] = 1'b0;
        check_chan("prio", 0, 1, 2, DB ? 3 : 4, 127);
        apply_stimulus(0, 1'b0, 4);
        check_chan("prio_next", 0, 1, -4, DB ? 2 : 3, 123);

        @(negedge clk);
        clear  = 1'b1;
        nin[1] = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
        nin[1] = 1'b0;
        check_output("clr_diff_bus", longint'(diff_out), 0);
        check_output("clr_phase_bus", longint'(phase_count), 0);
        check_output("clr_phi_bus", longint'(phi_out), 0);
        apply_stimulus(1, 1'b0, 3);
        check_chan("after_clr", 1, 1, -3, 15, -3);

        // Asynchronous reset in the middle of a LEAD measurement, away from any clock edge.
        @(negedge clk);
        nin[0] = 1'b1;
        @(negedge clk);
        nin[0] = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("arst_diff_bus", longint'(diff_out), 0);
        check_output("arst_phase_bus", longint'(phase_count), 0);
        check_output("arst_phi_bus", longint'(phi_out), 0);
        @(negedge clk);
        reset      = 1'b1;
        seen_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (diff_valid[0]) seen_valid = 1'b1;
        end
        nout[0] = 1'b1;
        @(negedge clk);
        nout[0] = 1'b0;
        if (diff_valid[0]) seen_valid = 1'b1;
        check_output("arst_no_stale", longint'(seen_valid), 0);
        check_output("arst_diff0", get_diff(0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phasediff_array.md
Name: phasediff_array

Overview:
- N_CH-channel successor to the single-channel neuron phase detector used in the neuron control block.
- Per channel, it measures the signed lag in clk cycles between rising edges of the neuron oscillator (nin) and its reference/coupled oscillator (nout).
- Each channel keeps:
  - a modulo-PHASE_STEPS phase bin (phase_count),
  - a saturating signed accumulator (phi_out).
- Feeds the ONN coupling/weight-update logic.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 12, lag counter width; diff_out is CNT_W+1 bits signed.
- MAX_CNT, 4095, timeout limit in cycles; must be 1..2^CNT_W-1.
- PHASE_STEPS, 16, number of phase bins; phase_count wraps modulo this value.
- PC_W, 4, phase_count width per channel; must satisfy 2^PC_W >= PHASE_STEPS.
- ACC_W, 16, phi_out accumulator width (signed).
- DEADBAND, 0, magnitude of lag that does not step phase_count. Used only with PHASEDIFF_DEADBAND_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous clear of all channels. Same effect as reset, one-cycle pulse.
- nin  in  N_CH  neuron oscillator per channel; synchronous to clk.
- nout  in  N_CH  reference oscillator per channel; synchronous to clk.
- diff_out  out  N_CH*(CNT_W+1)  signed lag per channel; positive = nin leads.
- diff_valid  out  N_CH  one-cycle pulse when diff_out[ch] is updated.
- timeout  out  N_CH  one-cycle pulse when a measurement is abandoned.
- phase_count  out  N_CH*PC_W  phase bin per channel.
- phi_out  out  N_CH*ACC_W  signed saturating accumulator per channel.

Behaviour:
- Reset (reset=0, asynchronous) and clear (synchronous):
  - all outputs = 0;
  - prev_nin/prev_nout = 0;
  - FSM = IDLE;
  - cnt = 0.
- Edge detect: rin = nin & ~prev_nin and rout = nout & ~prev_nout, combinational from the registered previous value. prev registers update every cycle.
- Lag definition: nin rises at cycle t and nout at t+k gives diff = +k; the mirror case gives -k. Simultaneous edges give 0.
- Latency: diff_valid and diff_out are registered, asserted the cycle after the closing edge is sampled.
- phase_count and phi_out update in the same cycle diff_valid is high; they reflect the new diff then.
- FSM per channel: IDLE, LEAD (nin seen, waiting for nout), LAG (nout seen, waiting for nin).
  - IDLE:
    - rin & rout -> emit diff 0, stay IDLE.
    - rin only -> LEAD, cnt=1.
    - rout only -> LAG, cnt=1.
  - LEAD:
    - rout -> emit +cnt, go to IDLE. Closing edge has priority; an rin in the same cycle is discarded.
    - else rin -> restart, cnt=1, no output.
    - else cnt==MAX_CNT -> timeout pulse, go to IDLE, no diff_valid.
    - else cnt+1.
  - LAG: mirror of LEAD, emitting -cnt.
- phase_count on diff_valid:
  - diff>0 -> +1; PHASE_STEPS-1 wraps to 0.
  - diff<0 -> -1; 0 wraps to PHASE_STEPS-1.
  - diff=0 -> hold.
- phi_out on diff_valid: phi_out + sign-extended diff, saturating at +(2^(ACC_W-1)-1) and -2^(ACC_W-1). No wrap.
- Channels are fully independent; no shared arbitration.
- clear asserted together with an edge: clear wins and the edge is not registered as an opening.

Optional Feature:
- Macro: PHASEDIFF_DEADBAND_EN.
- Defined: when |diff| <= DEADBAND, phase_count holds. diff_out, diff_valid and phi_out are unaffected.
- Undefined: DEADBAND is ignored and any nonzero diff steps phase_count.

Decomposition:
- Package phasediff_pkg holds:
  - state enum phd_state_t {IDLE, LEAD, LAG};
  - width helper constants;
  - the saturating-add function for the accumulator.
- Sub-module phasediff_ch implements one channel (edge detect, FSM, counter, phase bin, accumulator).
- phasediff_array instantiates N_CH copies with a generate loop and packs the outputs.

Test Plan:
- Ch0: nin rises at cycle 10, nout at cycle 13 -> diff_valid[0] pulse at cycle 14, diff_out=+3, phase_count 0->1, phi_out=3.
- Ch1: nout at cycle 20, nin at cycle 25 -> diff_out=-5; phase_count wraps 0->15; phi_out=-5.
- Ch2: nin and nout rise in the same cycle -> diff_out=0, phase_count held, phi_out unchanged.
- MAX_CNT=8, nin rises with no nout -> timeout pulse 9 cycles later, no diff_valid, FSM back in IDLE.
- ACC_W=8, repeated +100 lags -> phi_out saturates at 127. Assert reset=0 mid-LEAD -> all outputs 0 immediately, no stale diff after release.
- PHASEDIFF_DEADBAND_EN with DEADBAND=2, lag +2 -> phase_count held; lag +3 -> phase_count +1.
